// File: rtl/car_collision_scanner.sv
// car_collision_scanner: scans car slots against the frog one per clock, reports hit/miss, tracks lives
// Ports: i_Clk/i_Rst (sync, active-high); i_scan_start request; i_frog_x/y frog cell;
//   i_cars_x/y packed car cells (car k at [5k+4:5k] / [4k+3:4k]); o_busy in LATCH/SCAN;
//   o_hit_valid one-cycle result pulse; o_hit/o_hit_idx held result; o_lives; o_game_over sticky.
// Macro WRAP_HITBOX_EN: car cells wrap modulo GRID_W instead of being clipped at the right edge.
module car_collision_scanner #(
  parameter int NUM_CARS   = 4,
  parameter int GRID_W     = 20,
  parameter int CAR_W      = 1,
  parameter int LIVES_INIT = 3,
  localparam int IDX_W     = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_scan_start,
  input  logic [4:0]            i_frog_x,
  input  logic [3:0]            i_frog_y,
  input  logic [5*NUM_CARS-1:0] i_cars_x,
  input  logic [4*NUM_CARS-1:0] i_cars_y,
  output logic                  o_busy,
  output logic                  o_hit_valid,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_hit_idx,
  output logic [1:0]            o_lives,
  output logic                  o_game_over
);
  typedef enum logic [1:0] {IDLE, LATCH, SCAN, OVER} state_t;
  state_t state_q, state_d;
  logic [4:0] frog_x_q, frog_x_d;
  logic [3:0] frog_y_q, frog_y_d;
  logic [5*NUM_CARS-1:0] cars_x_q, cars_x_d;
  logic [4*NUM_CARS-1:0] cars_y_q, cars_y_d;
  logic [IDX_W-1:0] idx_q, idx_d, hit_idx_q, hit_idx_d;
  logic busy_q, busy_d, valid_q, valid_d, hit_q, hit_d, over_q, over_d;
  logic [1:0] lives_q, lives_d;
  logic [4:0] cur_x;
  logic [3:0] cur_y;
  logic [5:0] fx6, cx6, off;
  logic scan, latch, car_hit, done, game_end;
  always_comb begin
    scan = state_q == SCAN;
    latch = state_q == LATCH;
    cur_x = cars_x_q[int'(idx_q)*5 +: 5];
    cur_y = cars_y_q[int'(idx_q)*4 +: 4];
    fx6 = {1'b0, frog_x_q};
    cx6 = {1'b0, cur_x};
    // off = distance from the car's left cell to the frog; a hit needs off < CAR_W
`ifdef WRAP_HITBOX_EN
    off = fx6 >= cx6 ? fx6 - cx6 : fx6 + 6'(GRID_W) - cx6;
`else
    off = fx6 >= cx6 ? fx6 - cx6 : 6'd63;
`endif
    car_hit = fx6 < 6'(GRID_W) && cx6 < 6'(GRID_W) && frog_y_q == cur_y && off < 6'(CAR_W);
    done = scan && (car_hit || idx_q == IDX_W'(NUM_CARS - 1));
    game_end = scan && car_hit && lives_q == 2'd1;
    state_d = state_q == IDLE ? (i_scan_start ? LATCH : IDLE) :
              latch ? SCAN :
              scan ? (done ? (game_end ? OVER : IDLE) : SCAN) : OVER;
    frog_x_d = latch ? i_frog_x : frog_x_q;
    frog_y_d = latch ? i_frog_y : frog_y_q;
    cars_x_d = latch ? i_cars_x : cars_x_q;
    cars_y_d = latch ? i_cars_y : cars_y_q;
    idx_d = latch ? '0 : scan ? idx_q + 1'b1 : idx_q;
    valid_d = done;
    hit_d = done ? car_hit : hit_q;
    hit_idx_d = done ? (car_hit ? idx_q : '0) : hit_idx_q;
    lives_d = done && car_hit ? lives_q - 2'd1 : lives_q;
    over_d = over_q | game_end;
    busy_d = state_d == LATCH || state_d == SCAN;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      frog_x_q <= '0;
      frog_y_q <= '0;
      cars_x_q <= '0;
      cars_y_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      hit_q <= 1'b0;
      hit_idx_q <= '0;
      lives_q <= 2'(LIVES_INIT);
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      cars_x_q <= cars_x_d;
      cars_y_q <= cars_y_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      hit_q <= hit_d;
      hit_idx_q <= hit_idx_d;
      lives_q <= lives_d;
      over_q <= over_d;
    end
  end
  assign o_busy = busy_q;
  assign o_hit_valid = valid_q;
  assign o_hit = hit_q;
  assign o_hit_idx = hit_idx_q;
  assign o_lives = lives_q;
  assign o_game_over = over_q;
endmodule

// File: tb/tb_car_collision_scanner.sv
// tb_car_collision_scanner: directed scans with a scoreboard queue checked by a separate result monitor
module tb_car_collision_scanner;
  localparam int NC = 4;
`ifdef WRAP_HITBOX_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef struct {logic hit; logic [1:0] idx; logic [1:0] lives; logic over;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0] frog_x = '0;
  logic [3:0] frog_y = '0;
  logic [19:0] cars_x = '0;
  logic [15:0] cars_y = '0;
  logic busy, hit_valid, hit, game_over;
  logic [1:0] hit_idx, lives;
  exp_t q[$];
  int total = 0, bad = 0, lives_m = 3;
  car_collision_scanner #(.NUM_CARS(NC), .GRID_W(20), .CAR_W(2), .LIVES_INIT(3)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_scan_start(start), .i_frog_x(frog_x), .i_frog_y(frog_y),
    .i_cars_x(cars_x), .i_cars_y(cars_y), .o_busy(busy), .o_hit_valid(hit_valid), .o_hit(hit),
    .o_hit_idx(hit_idx), .o_lives(lives), .o_game_over(game_over));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (hit_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got pulse expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hit", int'(hit), int'(e.hit));
        chk("hit_idx", int'(hit_idx), int'(e.idx));
        chk("lives", int'(lives), int'(e.lives));
        chk("game_over", int'(game_over), int'(e.over));
      end
    end
  end
  // Called just after a rising edge; E0 is the next edge.
  task automatic scan(input logic [4:0] fx, input logic [3:0] fy, input logic [19:0] cx,
                      input logic [15:0] cy, input bit eh, input int ei, input bit perturb);
    int n, bc, lat;
    exp_t e;
    if (eh) lives_m--;
    e.hit = eh;
    e.idx = eh ? 2'(ei) : 2'd0;
    e.lives = 2'(lives_m);
    e.over = lives_m == 0;
    q.push_back(e);
    lat = eh ? 2 + ei : NC + 1;
    frog_x = fx;
    frog_y = fy;
    cars_x = cx;
    cars_y = cy;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    bc = int'(busy);
    while (!hit_valid && n < 20) begin
      if (perturb && n == 1) begin
        cars_x = {4{5'd5}};
        frog_y = 4'd1;
      end
      start = perturb && n == 2;
      @(posedge clk);
      #1;
      n++;
      if (busy) bc++;
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("busy_cycles", bc, lat);
  endtask
  initial begin
    int bz;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_lives", int'(lives), 3);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_valid", int'(hit_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    @(posedge clk);
    #1;
    scan(5'd5, 4'd2, {5'd12, 5'd9, 5'd5, 5'd0}, {4'd3, 4'd2, 4'd2, 4'd1}, 1'b1, 1, 1'b0);
    scan(5'd5, 4'd0, {5'd12, 5'd9, 5'd5, 5'd0}, {4'd3, 4'd2, 4'd2, 4'd1}, 1'b0, 0, 1'b0);
    scan(5'd5, 4'd0, {5'd12, 5'd9, 5'd5, 5'd0}, {4'd3, 4'd2, 4'd2, 4'd1}, 1'b0, 0, 1'b1);
    scan(5'd25, 4'd4, {4{5'd25}}, {4{4'd4}}, 1'b0, 0, 1'b0);
    scan(5'd10, 4'd4, {5'd9, 5'd25, 5'd30, 5'd25}, {4{4'd4}}, 1'b1, 3, 1'b0);
    chk("lives_before_over", int'(lives), 1);
    scan(5'd5, 4'd2, {5'd12, 5'd9, 5'd5, 5'd0}, {4'd3, 4'd2, 4'd2, 4'd1}, 1'b1, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("over_lives", int'(lives), 0);
    chk("over_flag", int'(game_over), 1);
    start = 1'b1;
    bz = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy) bz++;
    end
    start = 1'b0;
    chk("over_busy", bz, 0);
    chk("over_lives_hold", int'(lives), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lives_m = 3;
    chk("rerst_lives", int'(lives), 3);
    chk("rerst_over", int'(game_over), 0);
    frog_x = 5'd5;
    frog_y = 4'd2;
    cars_x = {5'd12, 5'd9, 5'd5, 5'd0};
    cars_y = {4'd3, 4'd2, 4'd2, 4'd1};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_lives", int'(lives), 3);
    chk("abort_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    scan(5'd0, 4'd4, {5'd25, 5'd25, 5'd25, 5'd19}, {4'd0, 4'd0, 4'd0, 4'd4}, WRAP, 0, 1'b0);
    scan(5'd19, 4'd4, {5'd25, 5'd25, 5'd25, 5'd18}, {4'd0, 4'd0, 4'd0, 4'd4}, 1'b1, 0, 1'b0);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
